renamed_register_file: RTL

- Architectural integer register file with per-register rename tags for the Tomasulo/ROB core; successor of the single-width tag-tracking register file.
- Parametrised data width, register count and ROB tag width; x0 hardwired to zero.
- Commit carries the destination index; adds a global flush for branch-mispredict recovery.
- Sits between the issue latch (operand/tag lookup, rd rename) and the ROB (in-order commit).

---
 rtl/renamed_register_file.sv | 107 ++++++++++
 1 files changed

// File: rtl/renamed_register_file.sv
// +---------------------------------------------------------------------------+
// | Module  : renamed_register_file                                           |
// | Purpose : Architectural integer register file with per-register ROB       |
// |           rename tags, commit forwarding and mispredict flush.            |
// | Revision: 1.0 - initial release                                           |
// +---------------------------------------------------------------------------+
`default_nettype none

module renamed_register_file #(
   parameter int XLEN      = 32,
   parameter int NUM_REGS  = 32,
   parameter int REG_IDX_W = 5,
   parameter int ROB_WIDTH = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 flush_in,
   input  logic                 issue_valid,
   input  logic [REG_IDX_W-1:0] issue_rs1,
   input  logic [REG_IDX_W-1:0] issue_rs2,
   input  logic [REG_IDX_W-1:0] issue_rd,
   input  logic [ROB_WIDTH-1:0] issue_rd_tag,
   output logic [XLEN-1:0]      rs_value_1,
   output logic [XLEN-1:0]      rs_value_2,
   output logic [ROB_WIDTH-1:0] rs_tag_1,
   output logic [ROB_WIDTH-1:0] rs_tag_2,
   output logic                 rs_valid_1,
   output logic                 rs_valid_2,
   input  logic                 commit_valid,
   input  logic [REG_IDX_W-1:0] commit_rd,
   input  logic [ROB_WIDTH-1:0] commit_tag,
   input  logic [XLEN-1:0]      commit_value
);

   logic [XLEN-1:0]      value_q [NUM_REGS];
   logic [XLEN-1:0]      value_d [NUM_REGS];
   logic [ROB_WIDTH-1:0] tag_q   [NUM_REGS];
   logic [ROB_WIDTH-1:0] tag_d   [NUM_REGS];
   logic [NUM_REGS-1:0]  busy_q;
   logic [NUM_REGS-1:0]  busy_d;

   logic                 commit_en;
   logic                 rename_en;
   logic                 fwd_1;
   logic                 fwd_2;

   assign commit_en = rdy_in & commit_valid & (commit_rd != '0);
   assign rename_en = rdy_in & issue_valid & ~flush_in & (issue_rd != '0);

   // Lookups read pre-update state, so an instruction never sees its own rename.
   always_comb begin
      fwd_1 = rdy_in & commit_valid & ~flush_in & busy_q[issue_rs1]
              & (tag_q[issue_rs1] == commit_tag) & (issue_rs1 != '0);
      fwd_2 = rdy_in & commit_valid & ~flush_in & busy_q[issue_rs2]
              & (tag_q[issue_rs2] == commit_tag) & (issue_rs2 != '0);

      rs_value_1 = fwd_1 ? commit_value : value_q[issue_rs1];
      rs_value_2 = fwd_2 ? commit_value : value_q[issue_rs2];
      rs_valid_1 = fwd_1 | ~busy_q[issue_rs1];
      rs_valid_2 = fwd_2 | ~busy_q[issue_rs2];
      rs_tag_1   = tag_q[issue_rs1];
      rs_tag_2   = tag_q[issue_rs2];
   end

   always_comb begin
      value_d = value_q;
      tag_d   = tag_q;
      busy_d  = busy_q;

      if (commit_en) begin
         value_d[commit_rd] = commit_value;
         // A tag mismatch means a younger producer still owns the register.
         if (busy_q[commit_rd] && (tag_q[commit_rd] == commit_tag)) begin
            busy_d[commit_rd] = 1'b0;
         end
      end

      if (rdy_in && flush_in) begin
         busy_d = '0;
      end else if (rename_en) begin
         tag_d[issue_rd]  = issue_rd_tag;
         busy_d[issue_rd] = 1'b1;
      end

      value_d[0] = '0;
      tag_d[0]   = '0;
      busy_d[0]  = 1'b0;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            value_q[i] <= '0;
            tag_q[i]   <= '0;
         end
         busy_q <= '0;
      end else begin
         value_q <= value_d;
         tag_q   <= tag_d;
         busy_q  <= busy_d;
      end
   end

endmodule

`default_nettype wire
